// File: rtl/vmem1_init_dbg.sv
// vmem1_init_dbg: VMEM1 init sweep plus CPU/spy arbitration of the map-1 RAM port
module vmem1_init_dbg #(
  parameter logic [23:0] INIT_DATA = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cpu_adr,
  input  logic [23:0] cpu_wdata,
  input  logic        cpu_rp,
  input  logic        cpu_wp,
  output logic        busy,
  input  logic        spy_req,
  input  logic        spy_we,
  input  logic [9:0]  spy_adr,
  input  logic [23:0] spy_wdata,
  output logic        spy_ack,
  output logic [23:0] spy_rdata,
  output logic [9:0]  ram_adr,
  output logic [23:0] ram_wdata,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [23:0] ram_q
);
  typedef enum logic [1:0] {INIT, IDLE, SPY_RD, SPY_DONE} state_t;
  state_t state, state_nx;
  logic [9:0] cnt;
  logic ack_q;
  logic [23:0] rdata_q;
  logic acc;
  logic init;
  assign acc = state == IDLE && spy_req && !cpu_rp && !cpu_wp;
  assign init = state == INIT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= init ? cnt + 10'd1 : 10'd0;
      ack_q <= (acc && spy_we) || state == SPY_RD;
      if (state == SPY_RD) rdata_q <= ram_q;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      INIT:     state_nx = cnt == 10'd1023 ? IDLE : INIT;
      IDLE:     state_nx = acc ? (spy_we ? SPY_DONE : SPY_RD) : IDLE;
      SPY_RD:   state_nx = SPY_DONE;
      SPY_DONE: state_nx = spy_req ? SPY_DONE : IDLE;
      default:  state_nx = INIT;
    endcase
  end
  // reset masks the outputs at once, ahead of the registers clearing
  always_comb begin
    busy = reset || init;
    spy_ack = ack_q && !reset;
    spy_rdata = reset ? 24'd0 : rdata_q;
    ram_adr = reset ? 10'd0 : init ? cnt : acc ? spy_adr : cpu_adr;
    ram_wdata = (reset || init) ? INIT_DATA : acc ? spy_wdata : cpu_wdata;
    ram_wren = reset ? 1'b0 : init ? 1'b1 : acc ? spy_we : cpu_wp;
    ram_rden = (reset || init) ? 1'b0 : acc ? !spy_we : cpu_rp && !cpu_wp;
  end
endmodule

// File: doc/vmem1_init_dbg.md
# vmem1_init_dbg

Write-side companion to the stage-1 virtual memory map (VMEM1, 1k x 24 dual-port RAM). After reset it sweeps all 1024 map-1 entries with a fixed value. It then arbitrates the RAM's write and read controls between the processor's map read/write strobes and a spy/debug port that reads and writes single entries. It sits between the CADR datapath and the VMEM1 RAM instance and owns the RAM's address, data and enable inputs.

## Interface
- INIT_DATA, 24'h000000, value written to every entry during the reset sweep

- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high; restarts the init sweep
- cpu_adr  in  10  processor map-1 address {vmap[4:0], mapi[12:8]}
- cpu_wdata  in  24  processor write data (vma[23:0])
- cpu_rp  in  1  processor map-1 read strobe (vm1rp)
- cpu_wp  in  1  processor map-1 write strobe (vm1wp)
- busy  out  1  high while the init sweep runs; processor must stall
- spy_req  in  1  spy request; level, held until spy_ack
- spy_we  in  1  1 = write, 0 = read; sampled with spy_req
- spy_adr  in  10  spy entry address
- spy_wdata  in  24  spy write data
- spy_ack  out  1  one-cycle completion pulse
- spy_rdata  out  24  spy read data; valid with spy_ack, held until the next spy read completes
- ram_adr  out  10  to RAM address
- ram_wdata  out  24  to RAM write data
- ram_wren  out  1  RAM write enable
- ram_rden  out  1  RAM read enable
- ram_q  in  24  RAM read data; 1-cycle registered latency

## Operation
- States: INIT, IDLE, SPY_RD, SPY_DONE.
- INIT
  - A 10-bit counter cnt drives ram_adr; ram_wren=1, ram_wdata=INIT_DATA, ram_rden=0, busy=1.
  - cnt increments every cycle.
  - On cnt==1023 the write completes and the state goes to IDLE; cnt wraps to 0.
  - CPU strobes and spy_req are ignored in INIT.
- IDLE, default pass-through
  - ram_adr=cpu_adr, ram_wdata=cpu_wdata, ram_wren=cpu_wp, ram_rden=cpu_rp & ~cpu_wp.
- The CPU always has priority. A spy request is accepted only in IDLE, in a cycle with spy_req=1 and cpu_rp=cpu_wp=0.
- Spy write accepted in cycle A
  - ram_adr=spy_adr, ram_wdata=spy_wdata, ram_wren=1 in A.
  - spy_ack=1 in A+1; state goes to SPY_DONE.
- Spy read accepted in cycle A
  - ram_adr=spy_adr, ram_rden=1, ram_wren=0 in A; state goes to SPY_RD.
  - In A+1 the RAM port returns to CPU pass-through. ram_q is the spy data and is registered into spy_rdata at the end of A+1.
  - spy_ack=1 in A+2; state goes to SPY_DONE.
- SPY_DONE
  - The RAM port is CPU pass-through.
  - The state stays here until spy_req=0, then goes to IDLE. This prevents double service of one request.
- Simultaneous cpu_rp and cpu_wp: the write wins (ram_rden=0), matching the RAM port rule.
- Spy write to an address the CPU reads in the next cycle: the CPU sees the new data (RAM write-before-read across cycles).

## Timing
- Reset values while reset=1
  - busy=1, spy_ack=0, spy_rdata=0, ram_wren=0, ram_rden=0, ram_adr=0, ram_wdata=INIT_DATA.
  - state=INIT, cnt=0.
- Sweep
  - The first cycle after reset deasserts writes address 0.
  - Address 1023 is written in cycle 1023.
  - busy falls at cycle 1024, the first IDLE cycle.
- Reset mid-sweep or mid-spy-access
  - Any access in flight is abandoned and no spy_ack is issued.
  - The sweep restarts from 0 on the cycle after reset falls.
- Spy latency, measured from the accepting cycle
  - Write: ack after 1 cycle.
  - Read: ack after 2 cycles.
  - CPU activity delays acceptance only, never an access already accepted.
- Minimum spacing between spy transactions: one cycle with spy_req=0.

## Test plan
- Reset then run: busy=1 for exactly 1024 cycles. Every address 0..1023 is written once with INIT_DATA=24'hA5A5A5, in ascending order. ram_wren=0 after that.
- Spy write adr=10'h155 data=24'h123456, then spy read adr=10'h155, no CPU traffic:
  - write ack 1 cycle after acceptance;
  - read ack 2 cycles after acceptance with spy_rdata=24'h123456.
- spy_req held high while cpu_rp pulses for 5 cycles: no spy access starts until the first cycle with cpu_rp=0. The CPU reads pass through unaltered.
- Spy read accepted with cpu_wp=1 in the next cycle to adr=10'h155, data=24'h0000FF: spy_rdata returns the old value 24'h123456, and the CPU write lands.
- cpu_rp=cpu_wp=1 in the same cycle: ram_wren=1, ram_rden=0.
- Reset asserted at sweep cycle 500: no spy_ack. The sweep restarts at address 0, and busy stays high for 1024 cycles after reset falls.
